// File: rtl/hazard_unit_if.sv
// D-stage hazard descriptors in from the decoder, stall and forward selects
// out to the datapath.
interface hazard_unit_if;
  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic [1:0] rs_tuse;
  logic [1:0] rt_tuse;
  logic [4:0] A3_D;
  logic [1:0] newdatatype;
  logic       stall;
  logic [1:0] fwd_rs_D;
  logic [1:0] fwd_rt_D;
  logic [1:0] fwd_rs_E;
  logic [1:0] fwd_rt_E;
  logic [1:0] fwd_rt_M;

  modport master (
    output rs_D, rt_D, rs_tuse, rt_tuse, A3_D, newdatatype,
    input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
  );

  modport slave (
    input  rs_D, rt_D, rs_tuse, rt_tuse, A3_D, newdatatype,
    output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
  );
endinterface

// File: rtl/hazard_unit.sv
// Tuse/Tnew hazard unit for the five-stage MIPS pipeline: tracks producers
// through E/M/W, raises the D-stage stall and drives D/E/M forward selects.
module hazard_unit (
  input  logic          clk,
  input  logic          reset,
  hazard_unit_if.slave  hz
);

  typedef enum logic [1:0] {NT_ALU = 2'b00, NT_DM = 2'b01, NT_PC = 2'b10, NT_NONE = 2'b11} newdata_e;
  typedef enum logic [1:0] {FWD_KEEP = 2'b00, FWD_PC8 = 2'b01, FWD_M = 2'b10, FWD_W = 2'b11} fwd_e;

  localparam logic [1:0] TUSE_NONE = 2'b11;

  logic [4:0] rs_E, rt_E, A3_E;
  logic [1:0] tnew_E;
  logic [4:0] rt_M, A3_M;
  logic [1:0] tnew_M;
  logic [4:0] A3_W;

  logic [1:0] tnew_D;
  logic [4:0] a3_entry;
  newdata_e   ndt;

  always_comb begin
    ndt      = newdata_e'(hz.newdatatype);
    tnew_D   = 2'd0;
    a3_entry = hz.A3_D;
    case (ndt)
      NT_ALU:  tnew_D = 2'd1;
      NT_DM:   tnew_D = 2'd2;
      NT_PC:   tnew_D = 2'd0;
      NT_NONE: a3_entry = '0;
      default: tnew_D = 2'd0;
    endcase
  end

  function automatic logic use_stall(input logic [4:0] src, input logic [1:0] tuse);
    return (tuse != TUSE_NONE) && (src != '0) &&
           (((A3_E == src) && (tnew_E > tuse)) || ((A3_M == src) && (tnew_M > tuse)));
  endfunction

  // First matching stage wins; an unready young producer blocks older matches.
  function automatic fwd_e fwd_sel_d(input logic [4:0] src);
    if (src == '0)       return FWD_KEEP;
    if (A3_E == src)     return (tnew_E == 2'd0) ? FWD_PC8 : FWD_KEEP;
    if (A3_M == src)     return (tnew_M == 2'd0) ? FWD_M : FWD_KEEP;
    if (A3_W == src)     return FWD_W;
    return FWD_KEEP;
  endfunction

  function automatic fwd_e fwd_sel_e(input logic [4:0] src);
    if (src == '0)       return FWD_KEEP;
    if (A3_M == src)     return (tnew_M == 2'd0) ? FWD_M : FWD_KEEP;
    if (A3_W == src)     return FWD_W;
    return FWD_KEEP;
  endfunction

  always_comb begin
    hz.stall    = use_stall(hz.rs_D, hz.rs_tuse) | use_stall(hz.rt_D, hz.rt_tuse);
    hz.fwd_rs_D = fwd_sel_d(hz.rs_D);
    hz.fwd_rt_D = fwd_sel_d(hz.rt_D);
    hz.fwd_rs_E = fwd_sel_e(rs_E);
    hz.fwd_rt_E = fwd_sel_e(rt_E);
    hz.fwd_rt_M = ((rt_M != '0) && (rt_M == A3_W)) ? FWD_W : FWD_KEEP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_E   <= '0;
      rt_E   <= '0;
      A3_E   <= '0;
      tnew_E <= '0;
      rt_M   <= '0;
      A3_M   <= '0;
      tnew_M <= '0;
      A3_W   <= '0;
    end else begin
      rt_M   <= rt_E;
      A3_M   <= A3_E;
      tnew_M <= (tnew_E == 2'd0) ? 2'd0 : tnew_E - 2'd1;
      A3_W   <= A3_M;
      if (hz.stall) begin
        rs_E   <= '0;
        rt_E   <= '0;
        A3_E   <= '0;
        tnew_E <= '0;
      end else begin
        rs_E   <= hz.rs_D;
        rt_E   <= hz.rt_D;
        A3_E   <= a3_entry;
        tnew_E <= tnew_D;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: instruction sequences with
// hand-computed stall and forward-select expectations.
module tb_hazard_unit;

  logic clk;
  logic reset;
  int unsigned n_vec;
  int unsigned n_bad;

  hazard_unit_if hif ();

  hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_vec(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] rsu,
                       input logic [1:0] rtu, input logic [4:0] a3, input logic [1:0] ndt);
    hif.rs_D        = rs;
    hif.rt_D        = rt;
    hif.rs_tuse     = rsu;
    hif.rt_tuse     = rtu;
    hif.A3_D        = a3;
    hif.newdatatype = ndt;
    #1;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 2'b11, 2'b11, 5'd0, 2'b11);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    nop();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;

    // 1: reset with arbitrary D inputs, release with all-zero D
    drive(5'd3, 5'd9, 2'b01, 2'b00, 5'd3, 2'b01);
    tick();
    tick();
    reset = 1'b0;
    drive(5'd0, 5'd0, 2'b00, 2'b00, 5'd0, 2'b00);
    chk_vec("rst_stall", {1'b0, hif.stall}, 2'b00);
    chk_vec("rst_fwd_rs_D", hif.fwd_rs_D, 2'b00);
    chk_vec("rst_fwd_rt_D", hif.fwd_rt_D, 2'b00);
    chk_vec("rst_fwd_rs_E", hif.fwd_rs_E, 2'b00);
    chk_vec("rst_fwd_rt_E", hif.fwd_rt_E, 2'b00);
    chk_vec("rst_fwd_rt_M", hif.fwd_rt_M, 2'b00);

    // 2: lw $1 ; addu $2,$1,$3
    rst_pulse();
    drive(5'd29, 5'd0, 2'b01, 2'b11, 5'd1, 2'b01);
    chk_vec("lu_lw_D_stall", {1'b0, hif.stall}, 2'b00);
    tick();
    drive(5'd1, 5'd3, 2'b01, 2'b01, 5'd2, 2'b00);
    chk_vec("lu_stall1", {1'b0, hif.stall}, 2'b01);
    tick();
    chk_vec("lu_stall2", {1'b0, hif.stall}, 2'b00);
    chk_vec("lu_fwd_rs_D", hif.fwd_rs_D, 2'b00);
    tick();
    nop();
    chk_vec("lu_fwd_rs_E", hif.fwd_rs_E, 2'b11);
    chk_vec("lu_fwd_rt_E", hif.fwd_rt_E, 2'b00);

    // 3: addu $4 ; beq $4,$5
    rst_pulse();
    drive(5'd1, 5'd2, 2'b01, 2'b01, 5'd4, 2'b00);
    tick();
    drive(5'd4, 5'd5, 2'b00, 2'b00, 5'd0, 2'b11);
    chk_vec("br_stall1", {1'b0, hif.stall}, 2'b01);
    tick();
    chk_vec("br_stall2", {1'b0, hif.stall}, 2'b00);
    chk_vec("br_fwd_rs_D", hif.fwd_rs_D, 2'b10);
    chk_vec("br_fwd_rt_D", hif.fwd_rt_D, 2'b00);

    // 4: jal ; jr $31
    rst_pulse();
    drive(5'd0, 5'd0, 2'b11, 2'b11, 5'd31, 2'b10);
    tick();
    drive(5'd31, 5'd0, 2'b00, 2'b11, 5'd0, 2'b11);
    chk_vec("jr_stall", {1'b0, hif.stall}, 2'b00);
    chk_vec("jr_fwd_rs_D", hif.fwd_rs_D, 2'b01);

    // 5: addu $5 ; addu $5 ; addu $6,$5,$0 ; then lw $0 ; use $0
    rst_pulse();
    drive(5'd1, 5'd2, 2'b01, 2'b01, 5'd5, 2'b00);
    tick();
    drive(5'd3, 5'd4, 2'b01, 2'b01, 5'd5, 2'b00);
    tick();
    drive(5'd5, 5'd0, 2'b01, 2'b01, 5'd6, 2'b00);
    chk_vec("pri_stall", {1'b0, hif.stall}, 2'b00);
    chk_vec("pri_fwd_rs_D_young_blocks", hif.fwd_rs_D, 2'b00);
    tick();
    nop();
    chk_vec("pri_fwd_rs_E", hif.fwd_rs_E, 2'b10);
    chk_vec("pri_fwd_rt_E", hif.fwd_rt_E, 2'b00);
    drive(5'd29, 5'd0, 2'b01, 2'b11, 5'd0, 2'b01);
    tick();
    drive(5'd0, 5'd0, 2'b00, 2'b00, 5'd7, 2'b00);
    chk_vec("zero_stall", {1'b0, hif.stall}, 2'b00);
    chk_vec("zero_fwd_rs_D", hif.fwd_rs_D, 2'b00);

    // 6: lw $7 ; sw $7
    rst_pulse();
    drive(5'd29, 5'd0, 2'b01, 2'b11, 5'd7, 2'b01);
    tick();
    drive(5'd29, 5'd7, 2'b01, 2'b10, 5'd0, 2'b11);
    chk_vec("st_stall_D", {1'b0, hif.stall}, 2'b00);
    tick();
    nop();
    chk_vec("st_stall_E", {1'b0, hif.stall}, 2'b00);
    tick();
    chk_vec("st_fwd_rt_M", hif.fwd_rt_M, 2'b11);

    // 7: lw $1 ; beq $1 -> two-cycle stall, then W forward
    rst_pulse();
    drive(5'd29, 5'd0, 2'b01, 2'b11, 5'd1, 2'b01);
    tick();
    drive(5'd1, 5'd0, 2'b00, 2'b00, 5'd0, 2'b11);
    chk_vec("lw0_stall1", {1'b0, hif.stall}, 2'b01);
    tick();
    chk_vec("lw0_stall2", {1'b0, hif.stall}, 2'b01);
    tick();
    chk_vec("lw0_stall3", {1'b0, hif.stall}, 2'b00);
    chk_vec("lw0_fwd_rs_D", hif.fwd_rs_D, 2'b11);

    // 8: reset asserted mid-stall clears the records
    rst_pulse();
    drive(5'd29, 5'd0, 2'b01, 2'b11, 5'd1, 2'b01);
    tick();
    drive(5'd1, 5'd0, 2'b00, 2'b00, 5'd0, 2'b11);
    chk_vec("rs_mid_stall", {1'b0, hif.stall}, 2'b01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_vec("rs_after_reset_stall", {1'b0, hif.stall}, 2'b00);
    chk_vec("rs_after_reset_fwd", hif.fwd_rs_D, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard unit for the five-stage MIPS core. It consumes the per-instruction hazard descriptors the decoder produces in D stage: register addresses, rs/rt Tuse codes, destination register and new-data type. It tracks each in-flight producer's destination and Tnew through E/M/W, then raises the D-stage stall and drives forwarding mux selects for the D, E and M stages.

## Interface

- No parameters. Encodings are fixed.
  - Tuse: 2'b00 = 0, 2'b01 = 1, 2'b10 = 2, 2'b11 = unused.
  - New-data type: 2'b00 ALU, 2'b01 DM, 2'b10 PC, 2'b11 none.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `rs_D` input 5: D-stage rs field.
- `rt_D` input 5: D-stage rt field.
- `rs_tuse` input 2: decoder rs Tuse code.
- `rt_tuse` input 2: decoder rt Tuse code.
- `A3_D` input 5: D-stage destination register, already resolved from RegDst. It is 0 when RegWr is 0.
- `newdatatype` input 2: decoder new-data type.
- `stall` output 1: freeze PC and IF/ID, insert bubble into ID/EX.
- `fwd_rs_D`, `fwd_rt_D` output 2 each: 00 GRF, 01 E-stage PC+8, 10 M-stage result, 11 W-stage result.
- `fwd_rs_E`, `fwd_rt_E` output 2 each: 00 ID/EX value, 10 M-stage, 11 W-stage.
- `fwd_rt_M` output 2: 00 EX/MEM value, 11 W-stage (store data).

## Operation

- Internal stage records, each a register:
  - E: {rs_E, rt_E, A3_E, tnew_E}
  - M: {rt_M, A3_M, tnew_M}
  - W: {A3_W}
- Tnew on entry to E: ALU → 1, DM → 2, PC → 0, none → 0 with A3 forced to 0.
- Advance on every clock edge:
  - M ← E, with tnew_M = tnew_E − 1, saturating at 0.
  - W ← M. W-stage Tnew is always 0.
  - E ← D fields when stall = 0. E ← all-zero bubble when stall = 1.
- Stall is combinational and is the OR of four terms:
  - rs term: rs_tuse ≠ 11, rs_D ≠ 0, and either (A3_E = rs_D and tnew_E > tuse) or (A3_M = rs_D and tnew_M > tuse).
  - rt terms: identical to the rs term, using rt_D and rt_tuse.
- D-stage forward select, per operand (rs_D or rt_D):
  - 00 when the operand is 0.
  - Otherwise, search E then M then W and take the first stage whose A3 matches.
  - If that stage has Tnew = 0, select 01 / 10 / 11 for E / M / W.
  - If that stage has Tnew > 0, select 00. A stall is raised or the value is not yet needed.
  - An older match never overrides a younger one.
- E-stage forward select, per operand (rs_E or rt_E):
  - 00 when the operand is 0.
  - Otherwise, search M then W for a match. Select 10 on an M match only when tnew_M = 0, and 11 on a W match.
- M-stage select: `fwd_rt_M` = 11 when rt_M ≠ 0 and rt_M = A3_W, else 00.
- Register $0 is never a hazard source or a forward target.
- rs_tuse/rt_tuse = 11 suppresses stall only. Forward selects are computed regardless, and the datapath ignores them.

## Timing

- Reset, synchronous:
  - All stage records clear to 0.
  - Outputs settle the same cycle to stall = 0 and every select = 00, given D inputs of 0.
- All outputs are combinational from current D inputs and the stage registers. Zero-cycle latency.
- Stall duration depends on the producer in E:
  - lw in E, consumer Tuse 1: 1 cycle.
  - lw in E, consumer Tuse 0: 2 cycles.
  - ALU op in E, consumer Tuse 0: 1 cycle.
  - PC producer (jal/jalr): never stalls.
- Reset asserted during a stall:
  - stall drops in the cycle after the reset edge, because the records are empty.
  - The pending bubble is discarded.
- Stall with simultaneous E and M matches: the stall condition is the OR of both. Forward priority is still E over M over W.
- Bubble records carry A3 = 0 and can never match.

## Test plan

1. Reset:
   - Stimulus: reset = 1 for 2 cycles with arbitrary D inputs, then release with all D inputs at 0.
   - Required: stall = 0 and all five selects = 00.
2. Load-use:
   - Stimulus: `lw $1` (DM, A3 = 1) followed by `addu $2,$1,$3` (rs_tuse = 01).
   - Required: stall = 1 for exactly 1 cycle, then 0. When addu reaches E, fwd_rs_E = 11.
3. Branch after ALU:
   - Stimulus: `addu $4,...` followed by `beq $4,$5` (rs_tuse = 00, rt_tuse = 00).
   - Required: stall = 1 for 1 cycle. The next cycle fwd_rs_D = 10 and fwd_rt_D = 00.
4. Link forwarding:
   - Stimulus: `jal` (PC, A3 = 31) followed by `jr $31` (rs_tuse = 00).
   - Required: stall = 0 and fwd_rs_D = 01.
5. Priority and $0:
   - Stimulus: two back-to-back ALU writes to $5, then `addu $6,$5,$0` (rs_tuse = 01, rt_tuse = 01).
   - Required: fwd_rs_E = 10 (youngest producer wins) and fwd_rt_E = 00. An `lw $0` followed by a consumer of $0 gives stall = 0.
6. Store-data forward:
   - Stimulus: `lw $7` followed directly by `sw $7` (rt_tuse = 10).
   - Required: stall = 0 throughout. When sw is in M, fwd_rt_M = 11.
